stream_rr_arbiter: RTL and testbench



---
 rtl/stream_arb_pkg.sv | 36 +++
 rtl/stream_rr_pick.sv | 33 +++
 rtl/stream_rr_arbiter.sv | 141 ++++++++++++++
 tb/tb_stream_rr_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the stream round-robin arbiter family.
// rr_pick() is the reference round-robin search used by stream_rr_pick.
package stream_arb_pkg;

  localparam int MAX_REQ = 16;
  localparam int PTR_W   = $clog2(MAX_REQ);

  typedef enum logic {
    IDLE,
    LOCKED
  } lock_state_e;

  // One-hot grant for the first valid at or above ptr, wrapping at num_req.
  // Lanes at or above num_req are never granted.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [PTR_W-1:0]   ptr,
    input int                 num_req
  );
    logic [MAX_REQ-1:0] grant;
    logic               found;
    int                 idx;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= num_req) idx = idx - num_req;
      if ((k < num_req) && !found && valid[idx[PTR_W-1:0]]) begin
        grant[idx[PTR_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/stream_rr_pick.sv
// Combinational round-robin picker: one-hot grant plus binary index of the
// first valid requester at or after i_ptr (wrapping). Reusable by any arbiter.
module stream_rr_pick
  import stream_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_idx,
  output logic               o_any
);

  logic [MAX_REQ-1:0] w_valid_ext;
  logic [MAX_REQ-1:0] w_grant_ext;

  // Widen to the package width, search, then narrow and encode the index.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    w_valid_ext              = '0;
    w_valid_ext[NUM_REQ-1:0] = i_valid;
    w_grant_ext              = rr_pick(w_valid_ext, PTR_W'(i_ptr), NUM_REQ);
    o_grant                  = w_grant_ext[NUM_REQ-1:0];
    o_any                    = |w_grant_ext;
    o_grant_idx              = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (o_grant[i]) o_grant_idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin merge of NUM_REQ valid/ready streams into one registered stage.
// Each output beat carries its source index on out_id.
// Optional: define STREAM_RR_ARBITER_PKT_LOCK_EN to hold the grant on one
// requester from its first beat until its req_last beat.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [ID_W-1:0]               out_id,
  output logic                          out_last
);

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [ID_W-1:0]       r_out_id;
  logic                  r_out_last;
  logic [ID_W-1:0]       r_rr_ptr;

  logic                  w_stage_ready;
  logic [NUM_REQ-1:0]    w_arb_valid;
  logic [NUM_REQ-1:0]    w_grant;
  logic [ID_W-1:0]       w_grant_idx;
  logic                  w_any;
  logic                  w_xfer;
  logic                  w_ptr_load;
  logic [ID_W-1:0]       w_next_ptr;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_sel_last;

`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
  lock_state_e           r_lock_state;
  logic [ID_W-1:0]       r_owner;
`endif

  assign w_stage_ready = ~r_out_valid | out_ready;

  // Candidate set: everyone, or only the packet owner while locked.
  always_comb begin
`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
    w_arb_valid = req_valid;
    if (r_lock_state == LOCKED) w_arb_valid = req_valid & (NUM_REQ'(1) << r_owner);
    w_ptr_load  = w_xfer & w_sel_last;
`else
    w_arb_valid = req_valid;
    w_ptr_load  = w_xfer;
`endif
  end

  stream_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .i_valid     (w_arb_valid),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any)
  );

  assign req_ready  = w_grant & {NUM_REQ{w_stage_ready}};
  assign w_xfer     = w_any & w_stage_ready;
  assign w_next_ptr = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

  // One-hot AND-OR mux of the granted requester's payload and last flag.
  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sel_data = w_sel_data | (req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{w_grant[i]}});
      w_sel_last = w_sel_last | (req_last[i] & w_grant[i]);
    end
  end

  // Output stage: load on transfer (replacing any draining beat), else clear on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
      r_out_last  <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_id    <= w_grant_idx;
      r_out_last  <= w_sel_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Round-robin pointer moves just past the requester that won the last transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_ptr_load) begin
      r_rr_ptr <= w_next_ptr;
    end
  end

`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
  // Packet lock FSM: a non-last beat locks onto its requester until its last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_state <= IDLE;
      r_owner      <= '0;
    end else begin
      case (r_lock_state)
        IDLE: begin
          if (w_xfer && !w_sel_last) begin
            r_lock_state <= LOCKED;
            r_owner      <= w_grant_idx;
          end
        end
        LOCKED: begin
          if (w_xfer && w_sel_last) r_lock_state <= IDLE;
        end
        default: r_lock_state <= IDLE;
      endcase
    end
  end
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter with an expected-beat scoreboard.
// Expectations for the packet section follow STREAM_RR_ARBITER_PKT_LOCK_EN.
module tb_stream_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_id;
  logic            out_last;

  beat_t sb[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  stream_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_last  (req_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [1:0] id, input logic [31:0] data, input logic last);
    beat_t b;
    b.id   = id;
    b.data = data;
    b.last = last;
    sb.push_back(b);
  endtask

  task automatic set_lanes(input logic [7:0] base);
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 32'(base) + 32'(i);
  endtask

  // One clock: check req_ready and any beat leaving the stage at mid-cycle,
  // then advance to just after the next rising edge.
  task automatic step(input logic [N-1:0] exp_ready, input string tag);
    beat_t b;
    @(negedge clk);
    check({tag, "_ready"}, 64'(req_ready), 64'(exp_ready));
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check({tag, "_extra_beat"}, 64'(out_valid), 64'(0));
      end else begin
        b = sb.pop_front();
        check({tag, "_id"},   64'(out_id),   64'(b.id));
        check({tag, "_data"}, 64'(out_data), 64'(b.data));
        check({tag, "_last"}, 64'(out_last), 64'(b.last));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_id",    64'(out_id),    64'(0));
    check("rst_out_data",  64'(out_data),  64'(0));
    check("rst_out_last",  64'(out_last),  64'(0));
    check("rst_rr_ptr",    64'(dut.r_rr_ptr), 64'(0));
    rst_n = 1'b1;

    // Fair rotation: all valid, continuous out_ready.
    out_ready = 1'b1;
    req_valid = 4'b1111;
    set_lanes(8'hA0);
    for (int k = 0; k < 8; k++) begin
      push(2'(k % 4), 32'hA0 + 32'(k % 4), 1'b0);
      step(4'b0001 << (k % 4), "fair");
      check("fair_no_bubble", 64'(out_valid), 64'(1));
    end
    req_valid = '0;
    step(4'b0000, "fair_drain");
    check("fair_drained", 64'(out_valid), 64'(0));

    // Sparse wrap: move ptr to 2 via req 1, then alternate 3,1,3.
    set_lanes(8'h50);
    req_valid = 4'b0010;
    push(2'd1, 32'h51, 1'b0);
    step(4'b0010, "sparse_pre");
    req_valid = 4'b1010;
    push(2'd3, 32'h53, 1'b0);
    step(4'b1000, "sparse_a");
    push(2'd1, 32'h51, 1'b0);
    step(4'b0010, "sparse_b");
    push(2'd3, 32'h53, 1'b0);
    step(4'b1000, "sparse_c");
    check("sparse_ptr_wrap", 64'(dut.r_rr_ptr), 64'(0));

    // Backpressure: 5 stalled cycles, then drain+load with no bubble.
    out_ready = 1'b0;
    req_valid = 4'b1111;
    set_lanes(8'hC0);
    for (int k = 0; k < 5; k++) begin
      step(4'b0000, "stall");
      check("stall_data", 64'(out_data), 64'(32'h53));
      check("stall_id",   64'(out_id),   64'(3));
    end
    out_ready = 1'b1;
    push(2'd0, 32'hC0, 1'b0);
    step(4'b0001, "unstall");
    check("unstall_no_bubble", 64'(out_valid), 64'(1));
    push(2'd1, 32'hC1, 1'b0);
    step(4'b0010, "unstall_b");
    req_valid = 4'b0100;
    push(2'd2, 32'hC2, 1'b0);
    step(4'b0100, "grant2");

    // Idle: no valids, ptr holds at 3, then req 0 wins via wrap.
    req_valid = '0;
    step(4'b0000, "idle_drain");
    check("idle_valid_low", 64'(out_valid), 64'(0));
    step(4'b0000, "idle_b");
    step(4'b0000, "idle_c");
    check("idle_ptr_hold", 64'(dut.r_rr_ptr), 64'(3));
    req_valid = 4'b0001;
    push(2'd0, 32'hC0, 1'b0);
    step(4'b0001, "idle_wake");
    req_valid = '0;
    step(4'b0000, "idle_wake_drain");

    // Packet: req 1 sends 3 beats while req 0 and 2 stay valid.
    req_data[0*DW +: DW] = 32'h10;
    req_data[1*DW +: DW] = 32'h21;
    req_data[2*DW +: DW] = 32'h30;
    req_data[3*DW +: DW] = 32'h0;
    req_last  = 4'b0101;
    req_valid = 4'b0111;
`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
    push(2'd1, 32'h21, 1'b0);
    step(4'b0010, "pkt_b1");
    req_data[1*DW +: DW] = 32'h22;
    req_valid = 4'b0101;
    step(4'b0000, "pkt_owner_gap");
    req_valid = 4'b0111;
    push(2'd1, 32'h22, 1'b0);
    step(4'b0010, "pkt_b2");
    req_data[1*DW +: DW] = 32'h23;
    req_last  = 4'b0111;
    push(2'd1, 32'h23, 1'b1);
    step(4'b0010, "pkt_b3");
    req_valid = 4'b0101;
    req_last  = 4'b0101;
    push(2'd2, 32'h30, 1'b1);
    step(4'b0100, "pkt_next");
`else
    push(2'd1, 32'h21, 1'b0);
    step(4'b0010, "pkt_b1");
    req_data[1*DW +: DW] = 32'h22;
    push(2'd2, 32'h30, 1'b1);
    step(4'b0100, "pkt_r2");
    push(2'd0, 32'h10, 1'b1);
    step(4'b0001, "pkt_r0");
    push(2'd1, 32'h22, 1'b0);
    step(4'b0010, "pkt_b2");
`endif
    req_valid = '0;
    req_last  = '0;
    step(4'b0000, "pkt_drain");

    // Reset mid-stream: outputs clear asynchronously, in-flight beat dropped.
    set_lanes(8'hE0);
    req_valid = 4'b0010;
    push(2'd1, 32'hE1, 1'b0);
    step(4'b0010, "pre_reset");
    check("pre_reset_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'(0));
    check("async_rst_id",    64'(out_id),    64'(0));
    check("async_rst_data",  64'(out_data),  64'(0));
    check("async_rst_ptr",   64'(dut.r_rr_ptr), 64'(0));
    sb.delete();
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid = 4'b1111;
    push(2'd0, 32'hE0, 1'b0);
    step(4'b0001, "post_reset");
    req_valid = '0;
    step(4'b0000, "post_reset_drain");

    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
